// File: rtl/busca_prefetch_pkg.sv
// Shared constants for the instruction fetch stage and the main controller (Controle):
// instruction size, reset PC, MIPS opcodes and a constant log2 helper.
package busca_prefetch_pkg;

   localparam int          INSTR_BYTES      = 4;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   // Ceiling log2 usable in parameter and port declarations.
   function automatic int busca_clog2(input int value);
      int result;
      int rest;
      result = 0;
      rest   = value - 1;
      while (rest > 0) begin
         result = result + 1;
         rest   = rest >>> 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/busca_prefetch_fila.sv
// Synchronous FIFO used as the prefetch buffer; flush clears it and wins over a same-cycle push.
// The head entry is read straight from the storage flops.
module fila_sincrona
   import busca_prefetch_pkg::*;
#(
   parameter int W     = 64,
   parameter int DEPTH = 4
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        push,
   input  logic [W-1:0]                push_data,
   input  logic                        pop,
   input  logic                        flush,
   output logic [W-1:0]                head_data,
   output logic [busca_clog2(DEPTH):0] count,
   output logic                        empty,
   output logic                        full
);

   localparam int PW = busca_clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [W-1:0]  mem_d [DEPTH];
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          push_ok_s, pop_ok_s;

   assign empty     = (count_q == '0);
   assign full      = (count_q == CW'(DEPTH));
   assign count     = count_q;
   assign head_data = mem_q[rd_ptr_q];

   // Next-state for storage, pointers and occupancy.
   always_comb begin
      push_ok_s = push & ~full;
      pop_ok_s  = pop & ~empty;
      mem_d     = mem_q;
      rd_ptr_d  = rd_ptr_q;
      wr_ptr_d  = wr_ptr_q;
      count_d   = count_q;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_ok_s) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PW'(1);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // State registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         mem_q    <= mem_d;
      end
   end

endmodule

// File: rtl/busca_prefetch.sv
// MIPS32 instruction fetch stage: in-order word prefetch into a FIFO, flushed on redirect.
// Define BUSCA_CONTADORES_EN to add the perf_stall_cnt / perf_flush_cnt counters.
module busca_prefetch
   import busca_prefetch_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter int                DATA_W   = 32,
   parameter int                DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_addr,
   output logic              imem_req_valid,
   input  logic              imem_req_ready,
   output logic [ADDR_W-1:0] imem_req_addr,
   input  logic              imem_resp_valid,
   input  logic [DATA_W-1:0] imem_resp_data,
   output logic              inst_valid,
   input  logic              inst_ready,
   output logic [DATA_W-1:0] inst_data,
   output logic [ADDR_W-1:0] inst_pc4
`ifdef BUSCA_CONTADORES_EN
   ,
   output logic [31:0]       perf_stall_cnt,
   output logic [31:0]       perf_flush_cnt
`endif
);

   localparam int                CW           = busca_clog2(DEPTH) + 1;
   localparam int                FW           = DATA_W + ADDR_W;
   localparam logic [ADDR_W-1:0] STEP_C       = ADDR_W'(INSTR_BYTES);
   localparam logic [ADDR_W-1:0] ALIGN_MASK_C = ~(ADDR_W'(INSTR_BYTES - 1));
   localparam logic [CW:0]       DEPTH_C      = (CW + 1)'(DEPTH);

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] fill_pc_q, fill_pc_d;
   logic [CW-1:0]     outstanding_q, outstanding_d;
   logic [CW-1:0]     drop_q, drop_d;

   logic              req_fire_s, resp_take_s, resp_drop_s, push_s, pop_s, credit_s;
   logic [ADDR_W-1:0] target_s;
   logic [CW:0]       occupancy_s;
   logic [FW-1:0]     push_data_s, head_s;
   logic [CW-1:0]     fifo_count_s;
   logic              fifo_empty_s, fifo_full_s;

   fila_sincrona #(
      .W     (FW),
      .DEPTH (DEPTH)
   ) u_fila (
      .clock     (clock),
      .reset     (reset),
      .push      (push_s),
      .push_data (push_data_s),
      .pop       (pop_s),
      .flush     (redirect_valid),
      .head_data (head_s),
      .count     (fifo_count_s),
      .empty     (fifo_empty_s),
      .full      (fifo_full_s)
   );

   assign imem_req_valid = ~reset & ~redirect_valid & credit_s;
   assign imem_req_addr  = pc_q;
   assign inst_valid     = ~fifo_empty_s;
   assign inst_data      = head_s[FW-1:ADDR_W];
   assign inst_pc4       = head_s[ADDR_W-1:0];

   // Credit, handshakes and next-state of the fetch counters.
   always_comb begin
      target_s    = redirect_addr & ALIGN_MASK_C;
      occupancy_s = {1'b0, fifo_count_s} + {1'b0, outstanding_q};
      credit_s    = ~fifo_full_s & (occupancy_s < DEPTH_C);
      req_fire_s  = imem_req_valid & imem_req_ready;
      resp_take_s = imem_resp_valid & (outstanding_q != '0);
      resp_drop_s = resp_take_s & (drop_q != '0);
      push_s      = resp_take_s & ~resp_drop_s;
      pop_s       = inst_valid & inst_ready & ~redirect_valid;
      push_data_s = {imem_resp_data, fill_pc_q + STEP_C};

      case ({req_fire_s, resp_take_s})
         2'b10:   outstanding_d = outstanding_q + CW'(1);
         2'b01:   outstanding_d = outstanding_q - CW'(1);
         default: outstanding_d = outstanding_q;
      endcase

      if (redirect_valid) begin
         pc_d      = target_s;
         fill_pc_d = target_s;
         // Every request still in flight after this cycle is stale; no request can issue now.
         drop_d    = outstanding_q - CW'(resp_take_s);
      end else begin
         pc_d      = req_fire_s  ? pc_q + STEP_C      : pc_q;
         fill_pc_d = push_s      ? fill_pc_q + STEP_C : fill_pc_q;
         drop_d    = resp_drop_s ? drop_q - CW'(1)    : drop_q;
      end
   end

   // Fetch state registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         pc_q          <= RESET_PC;
         fill_pc_q     <= RESET_PC;
         outstanding_q <= '0;
         drop_q        <= '0;
      end else begin
         pc_q          <= pc_d;
         fill_pc_q     <= fill_pc_d;
         outstanding_q <= outstanding_d;
         drop_q        <= drop_d;
      end
   end

`ifdef BUSCA_CONTADORES_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [31:0] flush_cnt_q, flush_cnt_d;

   assign perf_stall_cnt = stall_cnt_q;
   assign perf_flush_cnt = flush_cnt_q;

   // Counter increments; both wrap naturally at 2^32.
   always_comb begin
      if (inst_valid & ~inst_ready) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end else begin
         stall_cnt_d = stall_cnt_q;
      end
      if (redirect_valid) begin
         flush_cnt_d = flush_cnt_q + 32'd1;
      end else begin
         flush_cnt_d = flush_cnt_q;
      end
   end

   // Counter registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         stall_cnt_q <= 32'd0;
         flush_cnt_q <= 32'd0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end
`endif

endmodule

// File: tb/tb_busca_prefetch.sv
// Bench for busca_prefetch: directed scenarios plus randomized traffic against a queue-based model.
module tb_busca_prefetch;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int DEPTH  = 4;

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic              redirect_valid = 1'b0;
   logic [ADDR_W-1:0] redirect_addr = '0;
   logic              imem_req_valid;
   logic              imem_req_ready = 1'b1;
   logic [ADDR_W-1:0] imem_req_addr;
   logic              imem_resp_valid = 1'b0;
   logic [DATA_W-1:0] imem_resp_data = '0;
   logic              inst_valid;
   logic              inst_ready = 1'b1;
   logic [DATA_W-1:0] inst_data;
   logic [ADDR_W-1:0] inst_pc4;
`ifdef BUSCA_CONTADORES_EN
   logic [31:0]       perf_stall_cnt;
   logic [31:0]       perf_flush_cnt;
`endif

   always #5 clock = ~clock;

   busca_prefetch #(
      .ADDR_W   (ADDR_W),
      .DATA_W   (DATA_W),
      .DEPTH    (DEPTH),
      .RESET_PC (32'h0)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .redirect_valid  (redirect_valid),
      .redirect_addr   (redirect_addr),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_req_addr   (imem_req_addr),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .inst_valid      (inst_valid),
      .inst_ready      (inst_ready),
      .inst_data       (inst_data),
      .inst_pc4        (inst_pc4)
`ifdef BUSCA_CONTADORES_EN
      ,
      .perf_stall_cnt  (perf_stall_cnt),
      .perf_flush_cnt  (perf_flush_cnt)
`endif
   );

   typedef struct {
      logic [31:0] addr;
      int          epoch;
      int          due;
   } req_t;

   req_t        inflight[$];   // requests accepted by memory, oldest first
   logic [63:0] exp_q[$];      // words the core should deliver: {data, pc+4}
   logic [31:0] model_pc = 32'h0;
   logic [31:0] stall_m  = 32'd0;
   logic [31:0] flush_m  = 32'd0;
   int          epoch  = 0;
   int          cyc    = 0;
   int          lat_lo = 0;
   int          lat_hi = 0;
   int          n_cmp  = 0;
   int          n_err  = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
   endfunction

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // One clock: drive memory, check outputs against the model, advance the model.
   task automatic step();
      req_t r;
      logic do_pop;
      if (!reset && inflight.size() != 0 && cyc >= inflight[0].due) begin
         imem_resp_valid = 1'b1;
         imem_resp_data  = mem_word(inflight[0].addr);
      end else begin
         imem_resp_valid = 1'b0;
         imem_resp_data  = $urandom;
      end
      #1;
      if (reset) begin
         check_eq("req_valid_reset", {63'd0, imem_req_valid}, 64'd0);
         inflight.delete();
         exp_q.delete();
         model_pc = 32'h0;
         stall_m  = 32'd0;
         flush_m  = 32'd0;
         epoch++;
      end else begin
         check_eq("req_valid", {63'd0, imem_req_valid},
                  {63'd0, (!redirect_valid && (exp_q.size() + inflight.size() < DEPTH))});
         if (imem_req_valid) check_eq("req_addr", {32'd0, imem_req_addr}, {32'd0, model_pc});
         check_eq("inst_valid", {63'd0, inst_valid}, {63'd0, (exp_q.size() != 0)});
         if (inst_valid && exp_q.size() != 0) check_eq("inst_word", {inst_data, inst_pc4}, exp_q[0]);
`ifdef BUSCA_CONTADORES_EN
         check_eq("perf_stall", {32'd0, perf_stall_cnt}, {32'd0, stall_m});
         check_eq("perf_flush", {32'd0, perf_flush_cnt}, {32'd0, flush_m});
`endif
         do_pop = (exp_q.size() != 0) && inst_ready && !redirect_valid;
         if (exp_q.size() != 0 && !inst_ready) stall_m++;
         if (redirect_valid) flush_m++;
         if (do_pop) void'(exp_q.pop_front());
         if (imem_resp_valid) begin
            r = inflight.pop_front();
            if (r.epoch == epoch && !redirect_valid) exp_q.push_back({mem_word(r.addr), r.addr + 32'd4});
         end
         if (imem_req_valid && imem_req_ready) begin
            inflight.push_back('{addr: imem_req_addr, epoch: epoch,
                                 due: cyc + 1 + int'($urandom_range(lat_hi, lat_lo))});
            model_pc = model_pc + 32'd4;
         end
         if (redirect_valid) begin
            epoch++;
            exp_q.delete();
            model_pc = redirect_addr & 32'hFFFF_FFFC;
         end
      end
      @(posedge clock);
      cyc++;
      @(negedge clock);
   endtask

   task automatic do_reset();
      reset          = 1'b1;
      redirect_valid = 1'b0;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic wait_first(input string tag, input logic [31:0] exp_pc4);
      int n;
      n = 0;
      while (!inst_valid && n < 30) begin
         step();
         n++;
      end
      check_eq(tag, {31'd0, inst_valid, inst_pc4}, {31'd0, 1'b1, exp_pc4});
   endtask

   initial begin
      @(negedge clock);

      // Streaming from reset with a 1-cycle memory.
      do_reset();
      lat_lo = 0; lat_hi = 0;
      step();
      step();
      for (int k = 0; k < 6; k++) begin
         check_eq("t1_stream", {31'd0, inst_valid, inst_pc4}, {31'd0, 1'b1, 32'(4 * (k + 1))});
         step();
      end

      // Decode stalled: buffer fills to DEPTH and requests stop.
      do_reset();
      inst_ready = 1'b0;
      repeat (10) step();
      check_eq("t2_req_blocked", {63'd0, imem_req_valid}, 64'd0);
      inst_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         check_eq("t2_release", {31'd0, inst_valid, inst_pc4}, {31'd0, 1'b1, 32'(4 * (k + 1))});
         step();
      end
      repeat (6) step();

      // Memory not ready: address held.
      do_reset();
      step();
      step();
      imem_req_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         check_eq("t3_hold_addr", {31'd0, imem_req_valid, imem_req_addr}, {31'd0, 1'b1, 32'h8});
         step();
      end
      imem_req_ready = 1'b1;
      repeat (10) step();

      // Redirect with two requests in flight.
      do_reset();
      lat_lo = 2; lat_hi = 2;
      step();
      step();
      redirect_valid = 1'b1;
      redirect_addr  = 32'h100;
      step();
      redirect_valid = 1'b0;
      wait_first("t4_first_pc4", 32'h104);
      repeat (8) step();

      // Back-to-back redirects, the second one (unaligned target bits) wins.
      do_reset();
      lat_lo = 1; lat_hi = 1;
      step();
      step();
      redirect_valid = 1'b1;
      redirect_addr  = 32'h40;
      step();
      redirect_addr  = 32'h83;
      step();
      redirect_valid = 1'b0;
      wait_first("t5_first_pc4", 32'h84);
      repeat (10) step();

`ifdef BUSCA_CONTADORES_EN
      do_reset();
      check_eq("t6_stall_reset", {32'd0, perf_stall_cnt}, 64'd0);
      check_eq("t6_flush_reset", {32'd0, perf_flush_cnt}, 64'd0);
`endif

      // Randomized traffic with occasional redirects and resets.
      do_reset();
      lat_lo = 0; lat_hi = 3;
      repeat (3000) begin
         redirect_valid = ($urandom_range(99) < 4);
         redirect_addr  = $urandom_range(32'h0000_0FFF, 0);
         imem_req_ready = ($urandom_range(99) < 70);
         inst_ready     = ($urandom_range(99) < 70);
         reset          = ($urandom_range(999) == 0);
         step();
      end
      reset          = 1'b0;
      redirect_valid = 1'b0;
      repeat (5) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
